// File: rtl/uart_core_param_if.sv
// CPU-side bus of uart_core_param: TX/RX FIFO handshakes and sticky error flags.
interface uart_core_param_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data_in;
  logic                 write_tx_data;
  logic                 tx_buffer_full;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] rx_data_out;
  logic                 read_rx_data_ack;
  logic                 rx_data_present;
  logic                 rx_buffer_full;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 parity_err;
  logic                 clear_err;

  modport master (
    output tx_data_in, write_tx_data, read_rx_data_ack, clear_err,
    input  tx_buffer_full, tx_busy, rx_data_out, rx_data_present, rx_buffer_full,
           frame_err, overrun_err, parity_err
  );

  modport slave (
    input  tx_data_in, write_tx_data, read_rx_data_ack, clear_err,
    output tx_buffer_full, tx_busy, rx_data_out, rx_data_present, rx_buffer_full,
           frame_err, overrun_err, parity_err
  );
endinterface

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: 16x baud generator, TX/RX shift engines, TX/RX FIFOs.
// Optional parity bit enabled by defining UART_PARITY_EN (adds parameter PARITY_ODD).

module uart_core_param_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_pop;

  // Callers only push when there is room (or a pop frees it in the same cycle).
  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign dout   = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      if (push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
endmodule

module uart_core_param #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
`ifdef UART_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             reset,
  uart_core_param_if.slave bus,
  output logic             rs232_tx,
  input  logic             rs232_rx
);
  localparam int BAUD_DIV = CLK_HZ / (16 * BAUD);
  localparam int DW       = $clog2(BAUD_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HI
  } state_t;

  // Free-running 16x oversample tick shared by both directions.
  logic [DW-1:0] baud_cnt;
  logic          en16;

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      en16     <= 1'b0;
    end else if (baud_cnt == DW'(BAUD_DIV - 1)) begin
      baud_cnt <= '0;
      en16     <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt + DW'(1);
      en16     <= 1'b0;
    end
  end

  // ---------------- TX ----------------
  logic                 tx_push, tx_pop, tx_empty, tx_full, tx_done, tx_stop_last;
  logic [DATA_BITS-1:0] tx_head, tx_shift;
  state_t               tx_state;
  logic [3:0]           tx_tick;
  logic [2:0]           tx_bit;
  logic                 tx_stop_n;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_push      = bus.write_tx_data && !tx_full;
  assign tx_done      = en16 && (tx_tick == 4'd15);
  assign tx_stop_last = (tx_stop_n == 1'(STOP_BITS - 1));
  assign tx_pop       = !tx_empty &&
                        ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_done && tx_stop_last));

  uart_core_param_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(bus.tx_data_in),
    .dout(tx_head), .empty(tx_empty), .full(tx_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state  <= S_IDLE;
      rs232_tx  <= 1'b1;
      tx_tick   <= '0;
      tx_bit    <= '0;
      tx_stop_n <= 1'b0;
      tx_shift  <= '0;
`ifdef UART_PARITY_EN
      tx_par    <= 1'b0;
`endif
    end else begin
      if (en16) tx_tick <= tx_tick + 4'd1;
      case (tx_state)
        S_IDLE: if (tx_pop) begin
          tx_state <= S_START;
          rs232_tx <= 1'b0;
          tx_shift <= tx_head;
          tx_tick  <= '0;
`ifdef UART_PARITY_EN
          tx_par   <= ^tx_head ^ PARITY_ODD;
`endif
        end
        S_START: if (tx_done) begin
          tx_state <= S_DATA;
          rs232_tx <= tx_shift[0];
          tx_bit   <= '0;
        end
        S_DATA: if (tx_done) begin
          tx_shift <= tx_shift >> 1;
          if (tx_bit == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            tx_state  <= S_PARITY;
            rs232_tx  <= tx_par;
`else
            tx_state  <= S_STOP;
            rs232_tx  <= 1'b1;
            tx_stop_n <= 1'b0;
`endif
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            rs232_tx <= tx_shift[1];
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: if (tx_done) begin
          tx_state  <= S_STOP;
          rs232_tx  <= 1'b1;
          tx_stop_n <= 1'b0;
        end
`endif
        S_STOP: if (tx_done) begin
          if (!tx_stop_last) begin
            tx_stop_n <= 1'b1;
          end else if (tx_pop) begin
            // back-to-back frame: straight into the next start bit
            tx_state <= S_START;
            rs232_tx <= 1'b0;
            tx_shift <= tx_head;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_head ^ PARITY_ODD;
`endif
          end else begin
            tx_state <= S_IDLE;
            rs232_tx <= 1'b1;
          end
        end
        default: begin
          tx_state <= S_IDLE;
          rs232_tx <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx_buffer_full = tx_full;
  assign bus.tx_busy        = (tx_state != S_IDLE) || !tx_empty;

  // ---------------- RX ----------------
  logic [1:0]           rx_sync;
  logic                 rxd, rx_sample, rx_push_req, rx_push, rx_empty, rx_full;
  logic                 frm_set, ovr_set;
  logic [DATA_BITS-1:0] rx_head, rx_shift;
  state_t               rx_state;
  logic [3:0]           rx_tick;
  logic [2:0]           rx_bit;

  always_ff @(posedge clk) begin
    if (reset) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], rs232_rx};
  end
  assign rxd = rx_sync[1];

  assign rx_sample   = en16 && (rx_tick == 4'd15);
  assign rx_push_req = (rx_state == S_STOP) && rx_sample && rxd;
  assign frm_set     = (rx_state == S_STOP) && rx_sample && !rxd;
  // A pop in the same cycle makes room, so a full FIFO only overruns without an ack.
  assign rx_push     = rx_push_req && (!rx_full || bus.read_rx_data_ack);
  assign ovr_set     = rx_push_req && rx_full && !bus.read_rx_data_ack;

  uart_core_param_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(bus.read_rx_data_ack), .din(rx_shift),
    .dout(rx_head), .empty(rx_empty), .full(rx_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_tick  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      if (en16) rx_tick <= rx_tick + 4'd1;
      case (rx_state)
        S_IDLE: if (en16 && !rxd) begin
          rx_state <= S_START;
          rx_tick  <= '0;
        end
        S_START: if (en16 && rx_tick == 4'd7) begin
          // mid-bit re-check; a high line here was only a glitch
          rx_state <= rxd ? S_IDLE : S_DATA;
          rx_tick  <= '0;
          rx_bit   <= '0;
        end
        S_DATA: if (rx_sample) begin
          rx_shift <= {rxd, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            rx_state <= S_PARITY;
`else
            rx_state <= S_STOP;
`endif
          end else begin
            rx_bit <= rx_bit + 3'd1;
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: if (rx_sample) rx_state <= S_STOP;
`endif
        S_STOP:    if (rx_sample) rx_state <= S_WAIT_HI;
        S_WAIT_HI: if (rxd)       rx_state <= S_IDLE;
        default:   rx_state <= S_IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as clear_err wins.
  logic frame_err_q, overrun_err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      frame_err_q   <= frm_set | (frame_err_q & ~bus.clear_err);
      overrun_err_q <= ovr_set | (overrun_err_q & ~bus.clear_err);
    end
  end

`ifdef UART_PARITY_EN
  logic par_set, parity_err_q;
  assign par_set = (rx_state == S_PARITY) && rx_sample && (rxd != (^rx_shift ^ PARITY_ODD));
  always_ff @(posedge clk) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= par_set | (parity_err_q & ~bus.clear_err);
  end
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.frame_err       = frame_err_q;
  assign bus.overrun_err     = overrun_err_q;
  assign bus.rx_data_out     = rx_empty ? '0 : rx_head;
  assign bus.rx_data_present = !rx_empty;
  assign bus.rx_buffer_full  = rx_full;
endmodule

// File: tb/tb_uart_core_param.sv
// Directed + randomized bench for uart_core_param with a queue-based frame/FIFO model.
module tb_uart_core_param;
  localparam int CLK_HZ     = 1_000_000;
  localparam int BAUD       = 15625;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV        = CLK_HZ / (16 * BAUD);
  localparam int BIT        = 16 * DIV;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = 1 + DATA_BITS + PB + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic loop = 1'b0;
  logic drv_rx = 1'b1;
  logic rs232_tx;
  logic rs232_rx;

  assign rs232_rx = loop ? rs232_tx : drv_rx;

  uart_core_param_if #(.DATA_BITS(DATA_BITS)) bus();

  uart_core_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS),
    .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .rs232_tx(rs232_tx), .rs232_rx(rs232_rx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] mkframe(input logic [7:0] d, input logic stop);
    logic [15:0] f;
    f = 16'hFFFF;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef UART_PARITY_EN
    f[9]  = ^d;
    f[10] = stop;
`else
    f[9]  = stop;
`endif
    return f;
  endfunction

  task automatic send_raw(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drv_rx = bits[i];
      cyc(BIT);
    end
    drv_rx = 1'b1;
  endtask

  // Waits for a start edge, then samples every bit at its centre.
  task automatic decode_tx(output logic [7:0] b, output logic ok, output int gap);
    gap = 0;
    b = '0;
    while (rs232_tx !== 1'b0 && gap < 4 * BIT) begin
      cyc(1);
      gap++;
    end
    ok = (gap < 4 * BIT);
    cyc(BIT / 2);
    ok &= (rs232_tx === 1'b0);
    for (int i = 0; i < DATA_BITS; i++) begin
      cyc(BIT);
      b[i] = rs232_tx;
    end
`ifdef UART_PARITY_EN
    cyc(BIT);
    ok &= (rs232_tx === ^b);
`endif
    cyc(BIT);
    ok &= (rs232_tx === 1'b1);
  endtask

  task automatic wait_idle(input int limit);
    int w;
    w = 0;
    while (bus.tx_busy !== 1'b0 && w < limit) begin
      cyc(1);
      w++;
    end
  endtask

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] d, b;
  logic       ok;
  int         k, low, gap;
  logic [7:0] exp_q[$];
  logic [7:0] rxq[$];
  logic       exp_ovr;

  initial begin
    bus.tx_data_in = '0;
    bus.write_tx_data = 1'b0;
    bus.read_rx_data_ack = 1'b0;
    bus.clear_err = 1'b0;
    reset = 1'b1;
    cyc(3);
    check("rst_tx", rs232_tx, 1);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_txfull", bus.tx_buffer_full, 0);
    check("rst_present", bus.rx_data_present, 0);
    check("rst_rxfull", bus.rx_buffer_full, 0);
    check("rst_rxdata", bus.rx_data_out, 0);
    check("rst_errs", {bus.frame_err, bus.overrun_err, bus.parity_err}, 0);
    reset = 1'b0;
    cyc(2);

    // Single 0x55 frame: latency, start width, bit values, busy drop.
    d = 8'h55;
    bus.tx_data_in = d;
    bus.write_tx_data = 1'b1;
    cyc(1);
    bus.write_tx_data = 1'b0;
    k = 1;
    while (rs232_tx !== 1'b0 && k < 10) begin
      cyc(1);
      k++;
    end
    check("tx_latency_le2", k <= 2, 1);
    low = 0;
    while (rs232_tx === 1'b0 && low < 2 * BIT) begin
      low++;
      cyc(1);
    end
    check("start_width", (low >= BIT - DIV + 1) && (low <= BIT), 1);
    b = '0;
    cyc(BIT / 2);
    b[0] = rs232_tx;
    for (int i = 1; i < DATA_BITS; i++) begin
      cyc(BIT);
      b[i] = rs232_tx;
    end
    check("tx55_data", b, d);
`ifdef UART_PARITY_EN
    cyc(BIT);
    check("tx55_parity", rs232_tx, ^d);
`endif
    cyc(BIT);
    check("tx55_stop", rs232_tx, 1);
    check("tx55_busy_in_stop", bus.tx_busy, 1);
    wait_idle(BIT);
    check("tx55_busy_fall", bus.tx_busy, 0);
    check("tx55_idle_line", rs232_tx, 1);

    // Burst of FIFO_DEPTH+2 writes: engine takes one, FIFO holds DEPTH, the rest drop.
    for (int i = 0; i <= FIFO_DEPTH + 1; i++) begin
      d = 8'($urandom);
      bus.tx_data_in = d;
      bus.write_tx_data = 1'b1;
      if (i <= FIFO_DEPTH) exp_q.push_back(d);
      cyc(1);
      check("burst_txfull", bus.tx_buffer_full, (i >= FIFO_DEPTH));
    end
    bus.write_tx_data = 1'b0;
    for (int j = 0; j <= FIFO_DEPTH; j++) begin
      decode_tx(b, ok, gap);
      check("burst_data", b, exp_q[j]);
      check("burst_frame_ok", ok, 1);
      if (j > 0) check("burst_back_to_back", gap <= BIT / 2 + 4, 1);
    end
    wait_idle(2 * BIT);
    check("burst_busy_fall", bus.tx_busy, 0);
    check("burst_txfull_end", bus.tx_buffer_full, 0);
    exp_q.delete();

    // Loopback: directed bytes then random ones.
    loop = 1'b1;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'($urandom));
    foreach (exp_q[i]) begin
      bus.tx_data_in = exp_q[i];
      bus.write_tx_data = 1'b1;
      cyc(1);
    end
    bus.write_tx_data = 1'b0;
    wait_idle(12 * BIT * 9);
    check("loop_tx_done", bus.tx_busy, 0);
    cyc(BIT);
    foreach (exp_q[i]) begin
      check("loop_present", bus.rx_data_present, 1);
      check("loop_data", bus.rx_data_out, exp_q[i]);
      bus.read_rx_data_ack = 1'b1;
      cyc(1);
      bus.read_rx_data_ack = 1'b0;
    end
    check("loop_empty", bus.rx_data_present, 0);
    check("loop_no_errs", {bus.frame_err, bus.overrun_err, bus.parity_err}, 0);
    loop = 1'b0;
    exp_q.delete();

    // Receive FIFO_DEPTH+1 frames without acking.
    exp_ovr = 1'b0;
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      d = 8'($urandom);
      if (rxq.size() < FIFO_DEPTH) rxq.push_back(d);
      else exp_ovr = 1'b1;
      send_raw(mkframe(d, 1'b1), NBITS);
    end
    cyc(BIT);
    check("ovr_rxfull", bus.rx_buffer_full, rxq.size() == FIFO_DEPTH);
    check("ovr_flag", bus.overrun_err, exp_ovr);
    check("ovr_head", bus.rx_data_out, rxq[0]);
    check("ovr_no_frame_err", bus.frame_err, 0);
    bus.clear_err = 1'b1;
    cyc(1);
    bus.clear_err = 1'b0;
    check("ovr_cleared", bus.overrun_err, 0);
    while (rxq.size() > 0) begin
      check("ovr_drain", bus.rx_data_out, rxq.pop_front());
      bus.read_rx_data_ack = 1'b1;
      cyc(1);
      bus.read_rx_data_ack = 1'b0;
    end
    check("ovr_drained", bus.rx_data_present, 0);
    check("ovr_rxfull_end", bus.rx_buffer_full, 0);

    // Stop bit low on 0x3C: framing error, byte discarded.
    send_raw(mkframe(8'h3C, 1'b0), NBITS);
    cyc(BIT);
    check("frm_flag", bus.frame_err, 1);
    check("frm_discard", bus.rx_data_present, 0);
    bus.clear_err = 1'b1;
    cyc(1);
    bus.clear_err = 1'b0;
    check("frm_cleared", bus.frame_err, 0);

    // Short low glitch must not start a frame; a real frame afterwards still lands.
    drv_rx = 1'b0;
    cyc(2 * DIV);
    drv_rx = 1'b1;
    cyc(2 * BIT);
    check("glitch_no_data", bus.rx_data_present, 0);
    check("glitch_no_err", bus.frame_err, 0);
    d = 8'($urandom);
    send_raw(mkframe(d, 1'b1), NBITS);
    cyc(BIT);
    check("post_glitch_present", bus.rx_data_present, 1);
    check("post_glitch_data", bus.rx_data_out, d);
    bus.read_rx_data_ack = 1'b1;
    cyc(1);
    bus.read_rx_data_ack = 1'b0;

`ifdef UART_PARITY_EN
    // 0x01 with parity bit 0 (even parity wants 1): flagged but still delivered.
    send_raw({5'b11111, 1'b1, 1'b0, 8'h01, 1'b0}, NBITS);
    cyc(BIT);
    check("par_flag", bus.parity_err, 1);
    check("par_present", bus.rx_data_present, 1);
    check("par_data", bus.rx_data_out, 8'h01);
    bus.read_rx_data_ack = 1'b1;
    bus.clear_err = 1'b1;
    cyc(1);
    bus.read_rx_data_ack = 1'b0;
    bus.clear_err = 1'b0;
    check("par_cleared", bus.parity_err, 0);
`endif

    // Reset in the middle of an all-zero frame aborts it immediately.
    bus.tx_data_in = 8'h00;
    bus.write_tx_data = 1'b1;
    cyc(1);
    bus.write_tx_data = 1'b0;
    cyc(2 * BIT);
    check("midrst_line_low", rs232_tx, 0);
    reset = 1'b1;
    cyc(1);
    check("midrst_tx_high", rs232_tx, 1);
    check("midrst_busy", bus.tx_busy, 0);
    reset = 1'b0;
    cyc(2 * BIT);
    check("midrst_stays_idle", {rs232_tx, bus.tx_busy}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
